// File: rtl/sampler_sweep_controller.sv
// Per-variable proposal sequencer: for each iteration it walks every variable,
// fetches a segment, runs the sampler for a fixed latency and writes the result back.
module sampler_sweep_controller #(
  parameter int WIDTH           = 8,
  parameter int NUM_VARS        = 4,
  parameter int IDX_W           = 2,
  parameter int SAMPLER_LATENCY = 2
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_start,
  input  logic [15:0]             in_num_iterations,
  output logic                    out_seg_req,
  output logic [IDX_W-1:0]        out_var_index,
  input  logic                    in_seg_valid,
  input  logic signed [WIDTH-1:0] in_from,
  input  logic signed [WIDTH-1:0] in_to,
  input  logic [1:0]              in_type,
  input  logic signed [7:0]       in_weight,
  output logic signed [WIDTH-1:0] out_from,
  output logic signed [WIDTH-1:0] out_to,
  output logic [1:0]              out_type,
  output logic signed [7:0]       out_weight,
  output logic                    out_sampler_enable,
  input  logic signed [WIDTH-1:0] in_proposed_value,
  output logic                    out_wr_en,
  output logic [IDX_W-1:0]        out_wr_index,
  output logic signed [WIDTH-1:0] out_wr_value,
  output logic                    out_busy,
  output logic                    out_done,
  output logic                    out_invalid_seg,
  output logic [15:0]             out_iteration
);

  localparam int CNT_W = (SAMPLER_LATENCY > 1) ? $clog2(SAMPLER_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(SAMPLER_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SAMPLE,
    WRITE,
    NEXT,
    DONE
  } state_t;

  state_t                  state, state_nx;
  logic [15:0]             num_iter;
  logic [15:0]             iteration;
  logic [15:0]             iter_inc;
  logic [IDX_W-1:0]        var_index;
  logic [CNT_W-1:0]        lat_cnt;
  logic signed [WIDTH-1:0] seg_from, seg_to, wr_value;
  logic [1:0]              seg_type;
  logic signed [7:0]       seg_weight;
  logic                    invalid_seg;

  assign iter_inc = iteration + 16'd1;

  always_ff @(posedge in_clock) begin
    if (in_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx           = state;
    out_seg_req        = 1'b0;
    out_sampler_enable = 1'b0;
    out_wr_en          = 1'b0;
    out_done           = 1'b0;
    out_busy           = 1'b1;
    case (state)
      IDLE: begin
        out_busy = 1'b0;
        if (in_start) state_nx = (in_num_iterations == '0) ? DONE : REQ;
      end
      REQ: begin
        out_seg_req = 1'b1;
        if (in_seg_valid) state_nx = (in_type == 2'd0) ? NEXT : SAMPLE;
      end
      SAMPLE: begin
        out_sampler_enable = 1'b1;
        if (lat_cnt == '0) state_nx = WRITE;
      end
      WRITE: begin
        out_wr_en = 1'b1;
        state_nx  = NEXT;
      end
      NEXT: begin
        // The iteration count is compared post-increment, so the last sweep ends here.
        if (var_index == LAST_IDX) state_nx = (iter_inc == num_iter) ? DONE : REQ;
        else                       state_nx = REQ;
      end
      DONE: begin
        out_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      num_iter    <= '0;
      iteration   <= '0;
      var_index   <= '0;
      lat_cnt     <= '0;
      seg_from    <= '0;
      seg_to      <= '0;
      seg_type    <= '0;
      seg_weight  <= '0;
      wr_value    <= '0;
      invalid_seg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            num_iter    <= in_num_iterations;
            iteration   <= '0;
            var_index   <= '0;
            invalid_seg <= 1'b0;
          end
        end
        REQ: begin
          if (in_seg_valid) begin
            seg_from   <= in_from;
            seg_to     <= in_to;
            seg_type   <= in_type;
            seg_weight <= in_weight;
            if (in_type == 2'd0) invalid_seg <= 1'b1;
            else                 lat_cnt     <= LAT_LOAD;
          end
        end
        SAMPLE: begin
          if (lat_cnt == '0) wr_value <= in_proposed_value;
          else               lat_cnt  <= lat_cnt - 1'b1;
        end
        NEXT: begin
          if (var_index == LAST_IDX) begin
            var_index <= '0;
            iteration <= iter_inc;
          end else begin
            var_index <= var_index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_var_index   = var_index;
  assign out_wr_index    = var_index;
  assign out_wr_value    = wr_value;
  assign out_from        = seg_from;
  assign out_to          = seg_to;
  assign out_type        = seg_type;
  assign out_weight      = seg_weight;
  assign out_invalid_seg = invalid_seg;
  assign out_iteration   = iteration;

endmodule

// File: tb/tb_sampler_sweep_controller.sv
// Bench for sampler_sweep_controller: a run-level timeline model predicts every
// output cycle by cycle; a selector/sampler stand-in answers segment requests.
module tb_sampler_sweep_controller;

  localparam int WIDTH     = 8;
  localparam int NUM_VARS  = 4;
  localparam int IDX_W     = 2;
  localparam int LAT       = 2;
  localparam int SEL_DELAY = 1;

  logic                    clk = 1'b0;
  logic                    in_reset = 1'b1;
  logic                    in_start = 1'b0;
  logic [15:0]             in_num_iterations = '0;
  logic                    out_seg_req;
  logic [IDX_W-1:0]        out_var_index;
  logic                    in_seg_valid = 1'b0;
  logic signed [WIDTH-1:0] in_from = '0;
  logic signed [WIDTH-1:0] in_to = '0;
  logic [1:0]              in_type = '0;
  logic signed [7:0]       in_weight = '0;
  logic signed [WIDTH-1:0] out_from, out_to;
  logic [1:0]              out_type;
  logic signed [7:0]       out_weight;
  logic                    out_sampler_enable;
  logic signed [WIDTH-1:0] in_proposed_value = '0;
  logic                    out_wr_en;
  logic [IDX_W-1:0]        out_wr_index;
  logic signed [WIDTH-1:0] out_wr_value;
  logic                    out_busy, out_done, out_invalid_seg;
  logic [15:0]             out_iteration;

  sampler_sweep_controller #(
    .WIDTH(WIDTH), .NUM_VARS(NUM_VARS), .IDX_W(IDX_W), .SAMPLER_LATENCY(LAT)
  ) dut (
    .in_clock(clk), .in_reset(in_reset), .in_start(in_start),
    .in_num_iterations(in_num_iterations), .out_seg_req(out_seg_req),
    .out_var_index(out_var_index), .in_seg_valid(in_seg_valid),
    .in_from(in_from), .in_to(in_to), .in_type(in_type), .in_weight(in_weight),
    .out_from(out_from), .out_to(out_to), .out_type(out_type), .out_weight(out_weight),
    .out_sampler_enable(out_sampler_enable), .in_proposed_value(in_proposed_value),
    .out_wr_en(out_wr_en), .out_wr_index(out_wr_index), .out_wr_value(out_wr_value),
    .out_busy(out_busy), .out_done(out_done), .out_invalid_seg(out_invalid_seg),
    .out_iteration(out_iteration)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              req, en, wr, busy, done, inv, vidx_ok;
    logic [IDX_W-1:0]  vidx;
    logic signed [7:0] wval;
    logic [15:0]       iter;
    logic signed [7:0] from, to, w;
    logic [1:0]        typ;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int wr_count = 0, done_count = 0, req_cycles = 0;
  logic [3:0] wr_mask = '0;
  logic signed [7:0] last_wr = '0;

  // stimulus knobs and model state
  logic [1:0] type_tbl [NUM_VARS];
  int step = 0;
  int req_n = 0;
  int age = 0;
  logic spur_req = 1'b0;
  logic signed [7:0] m_from = '0, m_to = '0, m_w = '0;
  logic [1:0] m_typ = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic exp_t mk(input logic req, input logic en, input logic wr,
                              input logic busy, input logic done, input logic vok,
                              input int vidx, input int wval, input int iter, input logic inv);
    exp_t e;
    e.req = req; e.en = en; e.wr = wr; e.busy = busy; e.done = done; e.inv = inv;
    e.vidx_ok = vok; e.vidx = IDX_W'(vidx); e.wval = 8'(wval); e.iter = 16'(iter);
    e.from = m_from; e.to = m_to; e.w = m_w; e.typ = m_typ;
    return e;
  endfunction

  // Expected per-cycle outputs of a whole run, starting the cycle after start is accepted.
  task automatic build_run(input int n_iter);
    logic inv = 1'b0;
    int n = 0;
    for (int it = 0; it < n_iter; it++) begin
      for (int v = 0; v < NUM_VARS; v++) begin
        for (int c = 0; c <= SEL_DELAY; c++) q.push_back(mk(1, 0, 0, 1, 0, 1, v, 0, it, inv));
        m_from = -8'sd5; m_to = 8'(10 + step * n); m_w = 8'(step * n); m_typ = type_tbl[v];
        if (type_tbl[v] == 2'd0) begin
          inv = 1'b1;
        end else begin
          for (int c = 0; c < LAT; c++) q.push_back(mk(0, 1, 0, 1, 0, 1, v, 0, it, inv));
          q.push_back(mk(0, 0, 1, 1, 0, 1, v, 7 + step * n, it, inv));
        end
        q.push_back(mk(0, 0, 0, 1, 0, 1, v, 0, it, inv));
        n++;
      end
    end
    q.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, n_iter, inv));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, n_iter, inv));
  endtask

  // segment selector and sampler stand-in
  always @(negedge clk) begin
    in_seg_valid = 1'b0;
    if (spur_req && out_sampler_enable) begin
      in_seg_valid = 1'b1;
      in_from = 8'sd99; in_to = -8'sd1; in_type = 2'd1; in_weight = -8'sd7;
      spur_req = 1'b0;
    end else if (out_seg_req) begin
      if (age == SEL_DELAY) begin
        in_seg_valid = 1'b1;
        in_from = -8'sd5;
        in_to = 8'(10 + step * req_n);
        in_type = type_tbl[req_n % NUM_VARS];
        in_weight = 8'(step * req_n);
        in_proposed_value = 8'(7 + step * req_n);
        req_n++;
        age = 0;
      end else begin
        age++;
      end
    end else begin
      age = 0;
    end
  end

  // compare process
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_wr_en) begin
      wr_count++;
      wr_mask = wr_mask | (4'b0001 << out_wr_index);
      last_wr = out_wr_value;
    end
    if (out_done) done_count++;
    if (out_seg_req) req_cycles++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("seg_req", 32'(out_seg_req), 32'(e.req));
      chk("sampler_enable", 32'(out_sampler_enable), 32'(e.en));
      chk("wr_en", 32'(out_wr_en), 32'(e.wr));
      chk("busy", 32'(out_busy), 32'(e.busy));
      chk("done", 32'(out_done), 32'(e.done));
      chk("invalid_seg", 32'(out_invalid_seg), 32'(e.inv));
      chk("iteration", 32'(out_iteration), 32'(e.iter));
      chk("from", 32'(out_from), 32'(e.from));
      chk("to", 32'(out_to), 32'(e.to));
      chk("type", 32'(out_type), 32'(e.typ));
      chk("weight", 32'(out_weight), 32'(e.w));
      if (e.vidx_ok) chk("var_index", 32'(out_var_index), 32'(e.vidx));
      if (e.wr) begin
        chk("wr_index", 32'(out_wr_index), 32'(e.vidx));
        chk("wr_value", 32'(out_wr_value), 32'(e.wval));
      end
    end
  end

  task automatic start_run(input int n);
    @(negedge clk);
    wr_count = 0; done_count = 0; req_cycles = 0; wr_mask = '0; req_n = 0;
    build_run(n);
    in_num_iterations = 16'(n);
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (q.size() != 0 && k < limit) begin
      @(posedge clk); #2;
      k++;
    end
    chk(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic wait_enable(input string name, input int limit);
    int k = 0;
    @(posedge clk); #2;
    while (!out_sampler_enable && k < limit) begin
      @(posedge clk); #2;
      k++;
    end
    chk(name, 32'(out_sampler_enable), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_VARS; i++) type_tbl[i] = 2'd3;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_seg_req", 32'(out_seg_req), 32'd0);
    chk("rst_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_from", 32'(out_from), 32'd0);
    chk("rst_iteration", 32'(out_iteration), 32'd0);
    chk("rst_invalid", 32'(out_invalid_seg), 32'd0);
    @(negedge clk);
    in_reset = 1'b0;

    // 1: one sweep, constant segment and proposal
    step = 0;
    start_run(1);
    wait_drain("t1_drain", 60);
    chk("t1_wr_count", 32'(wr_count), 32'd4);
    chk("t1_wr_mask", 32'(wr_mask), 32'hF);
    chk("t1_last_wr", 32'(last_wr), 32'd7);
    chk("t1_iteration", 32'(out_iteration), 32'd1);
    chk("t1_done_count", 32'(done_count), 32'd1);

    // 2: zero iterations
    start_run(0);
    wait_drain("t2_drain", 10);
    chk("t2_req_cycles", 32'(req_cycles), 32'd0);
    chk("t2_wr_count", 32'(wr_count), 32'd0);
    chk("t2_done_count", 32'(done_count), 32'd1);

    // 3: invalid segment at index 2
    type_tbl[2] = 2'd0;
    start_run(1);
    wait_drain("t3_drain", 60);
    chk("t3_wr_count", 32'(wr_count), 32'd3);
    chk("t3_wr_mask", 32'(wr_mask), 32'b1011);
    chk("t3_invalid_after_done", 32'(out_invalid_seg), 32'd1);
    chk("t3_type_latched", 32'(out_type), 32'd3);

    // 4: three sweeps with varying segments and proposals
    type_tbl[0] = 2'd3; type_tbl[1] = 2'd1; type_tbl[2] = 2'd2; type_tbl[3] = 2'd3;
    step = 1;
    start_run(3);
    wait_drain("t4_drain", 150);
    chk("t4_wr_count", 32'(wr_count), 32'd12);
    chk("t4_iteration", 32'(out_iteration), 32'd3);
    chk("t4_done_count", 32'(done_count), 32'd1);
    chk("t4_last_wr", 32'(last_wr), 32'd18);
    chk("t4_invalid_cleared", 32'(out_invalid_seg), 32'd0);

    // 5: reset while sampling
    step = 0;
    for (int i = 0; i < NUM_VARS; i++) type_tbl[i] = 2'd3;
    start_run(1);
    wait_enable("t5_reach_sample", 20);
    @(negedge clk);
    q.delete();
    in_reset = 1'b1;
    @(posedge clk); #2;
    chk("t5_busy", 32'(out_busy), 32'd0);
    chk("t5_enable", 32'(out_sampler_enable), 32'd0);
    chk("t5_seg_req", 32'(out_seg_req), 32'd0);
    chk("t5_from_cleared", 32'(out_from), 32'd0);
    @(negedge clk);
    in_reset = 1'b0;
    m_from = '0; m_to = '0; m_w = '0; m_typ = '0;
    repeat (6) @(posedge clk);
    #2;
    chk("t5_wr_count", 32'(wr_count), 32'd0);
    chk("t5_done_count", 32'(done_count), 32'd0);
    chk("t5_still_idle", 32'(out_busy), 32'd0);

    // 6: start pulse and stray segment response while busy
    step = 1;
    start_run(1);
    wait_enable("t6_reach_sample", 20);
    spur_req = 1'b1;
    in_start = 1'b1;
    in_num_iterations = 16'd5;
    @(negedge clk);
    @(negedge clk);
    in_start = 1'b0;
    wait_drain("t6_drain", 60);
    chk("t6_wr_count", 32'(wr_count), 32'd4);
    chk("t6_done_count", 32'(done_count), 32'd1);
    chk("t6_iteration", 32'(out_iteration), 32'd1);
    chk("t6_from", 32'(out_from), 32'(-5));
    chk("t6_to", 32'(out_to), 32'd13);
    chk("t6_weight", 32'(out_weight), 32'd3);
    chk("t6_spur_consumed", 32'(spur_req), 32'd0);
    repeat (4) @(posedge clk);
    #2;
    chk("t6_idle_after", 32'(out_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sampler_sweep_controller.md
Name: sampler_sweep_controller

Overview:
Sequences the per-variable proposal loop of the MCMC constraint solver. For each iteration it sweeps variable indices 0..NUM_VARS-1. For each variable it requests a segment from the segment selector, latches from/to/type/weight, and drives the sampler for a fixed number of enabled cycles. It then captures the proposed value and issues a one-cycle write to the variable store. Sits between the segment-selection block, the sampler and the variable register file.

Parameters:
WIDTH, 8, bit width of from/to/proposed values
NUM_VARS, 4, number of variables swept per iteration (>=1)
IDX_W, 2, variable index width, must satisfy 2**IDX_W >= NUM_VARS
SAMPLER_LATENCY, 2, clock cycles sampler enable is held before the output is captured (>=1)

Ports:
in_clock  input  1  system clock, all logic on rising edge
in_reset  input  1  synchronous, active-high reset
in_start  input  1  starts a run; sampled only in IDLE
in_num_iterations  input  16  sweeps to perform; latched on accepted start
out_seg_req  output  1  request to segment selector, held until in_seg_valid
out_var_index  output  IDX_W  variable currently being processed
in_seg_valid  input  1  segment selector response valid (1-cycle pulse)
in_from  input  WIDTH signed  segment minimum
in_to  input  WIDTH signed  segment maximum
in_type  input  2  segment type: 1 exp-down, 2 exp-up, 3 uniform, 0 invalid
in_weight  input  8 signed  segment weight
out_from  output  WIDTH signed  latched from, to sampler
out_to  output  WIDTH signed  latched to, to sampler
out_type  output  2  latched type, to sampler
out_weight  output  8 signed  latched weight, to sampler
out_sampler_enable  output  1  sampler enable
in_proposed_value  input  WIDTH signed  sampler output
out_wr_en  output  1  one-cycle write strobe to variable store
out_wr_index  output  IDX_W  write address
out_wr_value  output  WIDTH signed  write data
out_busy  output  1  high in every state except IDLE
out_done  output  1  one-cycle pulse when a run completes
out_invalid_seg  output  1  sticky flag: a type-0 segment was received this run
out_iteration  output  16  number of completed iterations in the current run

Behaviour:
- Reset: state=IDLE. All outputs 0, including the latched segment registers, counters and out_invalid_seg.
- FSM states: IDLE, REQ, SAMPLE, WRITE, NEXT, DONE.
- IDLE:
  - When in_start=1: latch in_num_iterations, clear out_iteration, var index and out_invalid_seg.
  - If the latched count is 0, go to DONE; otherwise go to REQ.
  - in_start is ignored in every other state.
- REQ:
  - out_seg_req=1, out_var_index=current index.
  - When in_seg_valid=1, latch in_from/in_to/in_type/in_weight on the same edge and deassert out_seg_req next cycle. No timeout.
  - If the latched type is 0: set out_invalid_seg and go to NEXT, skipping sampling and write.
  - Otherwise go to SAMPLE and load the latency counter with SAMPLER_LATENCY-1.
- SAMPLE:
  - out_sampler_enable=1 for exactly SAMPLER_LATENCY consecutive cycles; the counter decrements each cycle.
  - On the cycle the counter equals 0, capture in_proposed_value into out_wr_value and go to WRITE.
- WRITE: out_wr_en=1 for exactly one cycle with out_wr_index = current index. Then go to NEXT.
- NEXT:
  - If index == NUM_VARS-1: index wraps to 0 and out_iteration increments. If the new out_iteration equals the latched count, go to DONE; otherwise go to REQ.
  - Else: index+1, then go to REQ.
- DONE: out_done=1 for one cycle, then go to IDLE. out_iteration and out_invalid_seg hold their values until the next accepted start.
- Latency for a valid variable, from in_seg_valid to out_wr_en: SAMPLER_LATENCY+1 cycles.
- out_from/out_to/out_type/out_weight are stable from latch until the next in_seg_valid.
- in_seg_valid outside REQ is ignored.
- in_reset has priority over every event. Mid-run it returns to IDLE in one cycle with no write or done pulse.

Test Plan:
1. Reset, then start with NUM_VARS=4, LAT=2, iterations=1; selector replies 1 cycle after each req with from=-5,to=10,type=3,w=0; sampler model returns 7 -> four out_wr_en pulses at indices 0,1,2,3 with value 7; out_done one cycle after final NEXT; out_iteration=1.
2. Start with iterations=0 -> no out_seg_req, out_busy high 1 cycle, out_done pulses, no writes.
3. Index 2 returns type=0 -> out_invalid_seg=1, no write for index 2, writes occur for 0,1,3; flag persists after done.
4. iterations=3, NUM_VARS=4 -> exactly 12 writes, index wraps 3->0 twice, out_iteration reaches 3, a single out_done.
5. Assert in_reset while in SAMPLE (enable high) -> next cycle state IDLE, enable/busy/seg_req 0, no out_wr_en, no out_done.
6. Pulse in_start while busy plus spurious in_seg_valid during SAMPLE -> the run is unaffected, the latched segment is unchanged, and the write count equals the expected count.
